// File: rtl/load_writeback_pkg.sv
// Shared types and helpers for the load/writeback unit.
// LOAD_UNALIGNED_EN adds LWL/LWR to the set of legal load types.
package load_writeback_pkg;

  typedef enum logic [2:0] {
    LT_LB  = 3'd0,
    LT_LBU = 3'd1,
    LT_LH  = 3'd2,
    LT_LHU = 3'd3,
    LT_LW  = 3'd4,
    LT_LWL = 3'd5,
    LT_LWR = 3'd6,
    LT_ILL = 3'd7
  } load_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_ERR
  } lw_state_e;

  function automatic logic load_legal(input load_type_e ld_type, input logic [1:0] offset);
    logic ok;
    ok = 1'b0;
    case (ld_type)
      LT_LB, LT_LBU: ok = 1'b1;
      LT_LH, LT_LHU: ok = ~offset[0];
      LT_LW:         ok = (offset == 2'b00);
`ifdef LOAD_UNALIGNED_EN
      LT_LWL, LT_LWR: ok = 1'b1;
`endif
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] load_byteenable(input load_type_e ld_type, input logic [1:0] offset);
    logic [3:0] be;
    case (ld_type)
      LT_LB, LT_LBU: be = 4'b0001 << offset;
      LT_LH, LT_LHU: be = offset[1] ? 4'b1100 : 4'b0011;
      default:       be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_writeback_if.sv
// Request, Avalon-MM read master and register-file write port bundle.
interface load_writeback_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_type;
  logic [4:0]  req_dest;
  logic [31:0] req_rt_old;

  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  logic        write_enable;
  logic [4:0]  write_address;
  logic [31:0] reg_data_in_1;

  modport slave (
    input  req_valid, req_addr, req_type, req_dest, req_rt_old,
    output req_ready,
    output avm_address, avm_read, avm_byteenable,
    input  avm_readdata, avm_waitrequest,
    output write_enable, write_address, reg_data_in_1
  );

  modport master (
    output req_valid, req_addr, req_type, req_dest, req_rt_old,
    input  req_ready,
    input  avm_address, avm_read, avm_byteenable,
    output avm_readdata, avm_waitrequest,
    input  write_enable, write_address, reg_data_in_1
  );

endinterface

// File: rtl/load_align.sv
// Combinational lane extraction and LWL/LWR merge of a little-endian read word.
// The merge paths exist only when LOAD_UNALIGNED_EN is defined.
import load_writeback_pkg::*;

module load_align (
  input  load_type_e  ld_type,
  input  logic [1:0]  offset,
  input  logic [31:0] readdata,
  input  logic [31:0] rt_old,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = readdata[{offset, 3'b000} +: 8];
  assign half_v = offset[1] ? readdata[31:16] : readdata[15:0];

`ifdef LOAD_UNALIGNED_EN
  logic [4:0]  lwl_sh;
  logic [4:0]  lwr_sh;
  logic [31:0] lwl_keep;
  logic [31:0] lwr_keep;

  // LWL keeps the low (3-k) bytes of rt, LWR keeps the high k bytes
  assign lwl_sh   = {2'd3 - offset, 3'b000};
  assign lwr_sh   = {offset, 3'b000};
  assign lwl_keep = ~(32'hFFFF_FFFF << lwl_sh);
  assign lwr_keep = ~(32'hFFFF_FFFF >> lwr_sh);
`else
  logic unused_rt_old;
  assign unused_rt_old = ^rt_old;
`endif

  always_comb begin
    result = readdata;
    case (ld_type)
      LT_LB:  result = {{24{byte_v[7]}}, byte_v};
      LT_LBU: result = {24'd0, byte_v};
      LT_LH:  result = {{16{half_v[15]}}, half_v};
      LT_LHU: result = {16'd0, half_v};
`ifdef LOAD_UNALIGNED_EN
      LT_LWL: result = (readdata << lwl_sh) | (rt_old & lwl_keep);
      LT_LWR: result = (readdata >> lwr_sh) | (rt_old & lwr_keep);
`endif
      default: result = readdata;
    endcase
  end

endmodule

// File: rtl/load_writeback.sv
// Load unit: accepts a load, reads one word over Avalon-MM, aligns it and writes rt.
// Build option LOAD_UNALIGNED_EN enables LWL/LWR; otherwise those types error out.
//   state    | meaning
//   ST_IDLE  | ready for a request
//   ST_READ  | avm_read asserted, waiting out waitrequest / timeout
//   ST_WRITE | one-cycle register-file write
//   ST_ERR   | one-cycle err pulse (illegal, misaligned or timed out)
import load_writeback_pkg::*;

module load_writeback #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  load_writeback_if.slave  bus,
  output logic             busy,
  output logic             err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  lw_state_e   state;
  load_type_e  type_q;
  logic [1:0]  offset_q;
  logic [4:0]  dest_q;
  logic [31:0] rt_old_q;
  logic [CW-1:0] wait_cnt;
  logic [31:0] align_result;
  load_type_e  req_type_e;

  assign req_type_e = load_type_e'(bus.req_type);

  load_align u_align (
    .ld_type  (type_q),
    .offset   (offset_q),
    .readdata (bus.avm_readdata),
    .rt_old   (rt_old_q),
    .result   (align_result)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state              <= ST_IDLE;
      bus.req_ready      <= 1'b1;
      bus.avm_read       <= 1'b0;
      bus.avm_address    <= '0;
      bus.avm_byteenable <= '0;
      bus.write_enable   <= 1'b0;
      bus.write_address  <= '0;
      bus.reg_data_in_1  <= '0;
      busy               <= 1'b0;
      err                <= 1'b0;
      type_q             <= LT_LB;
      offset_q           <= '0;
      dest_q             <= '0;
      rt_old_q           <= '0;
      wait_cnt           <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            busy          <= 1'b1;
            if (load_legal(req_type_e, bus.req_addr[1:0])) begin
              type_q             <= req_type_e;
              offset_q           <= bus.req_addr[1:0];
              dest_q             <= bus.req_dest;
              rt_old_q           <= bus.req_rt_old;
              wait_cnt           <= '0;
              bus.avm_read       <= 1'b1;
              bus.avm_address    <= {bus.req_addr[31:2], 2'b00};
              bus.avm_byteenable <= load_byteenable(req_type_e, bus.req_addr[1:0]);
              state              <= ST_READ;
            end else begin
              err   <= 1'b1;
              state <= ST_ERR;
            end
          end
        end
        ST_READ: begin
          if (!bus.avm_waitrequest) begin
            bus.avm_read       <= 1'b0;
            bus.avm_address    <= '0;
            bus.avm_byteenable <= '0;
            bus.write_enable   <= (dest_q != 5'd0);
            bus.write_address  <= dest_q;
            bus.reg_data_in_1  <= align_result;
            state              <= ST_WRITE;
          end else if (wait_cnt == TO_LAST) begin
            bus.avm_read       <= 1'b0;
            bus.avm_address    <= '0;
            bus.avm_byteenable <= '0;
            err                <= 1'b1;
            state              <= ST_ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WRITE: begin
          bus.write_enable  <= 1'b0;
          bus.write_address <= '0;
          bus.reg_data_in_1 <= '0;
          busy              <= 1'b0;
          bus.req_ready     <= 1'b1;
          state             <= ST_IDLE;
        end
        default: begin
          err           <= 1'b0;
          busy          <= 1'b0;
          bus.req_ready <= 1'b1;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_writeback.sv
// Directed self-checking bench for load_writeback (TIMEOUT_CYCLES = 4).
// Expectations for LWL follow LOAD_UNALIGNED_EN.
module tb_load_writeback;

  logic clk;
  logic reset;
  logic busy;
  logic err;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   wr_cnt  = 0;
  int   rd_cnt  = 0;
  int   wr0;
  int   rd0;

  load_writeback_if bus_if ();

  load_writeback #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .busy  (busy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle-level activity counters, sampled on the active edge
  always @(posedge clk) begin
    if (bus_if.write_enable === 1'b1) wr_cnt++;
    if (bus_if.avm_read === 1'b1) rd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present a request for one cycle; returns in the cycle after acceptance
  task automatic issue(input logic [2:0] t, input logic [31:0] a, input logic [4:0] d,
                       input logic [31:0] rt);
    bus_if.req_type   = t;
    bus_if.req_addr   = a;
    bus_if.req_dest   = d;
    bus_if.req_rt_old = rt;
    bus_if.req_valid  = 1'b1;
    tick();
    bus_if.req_valid  = 1'b0;
  endtask

  initial begin
    reset                  = 1'b0;
    bus_if.req_valid       = 1'b0;
    bus_if.req_addr        = '0;
    bus_if.req_type        = '0;
    bus_if.req_dest        = '0;
    bus_if.req_rt_old      = '0;
    bus_if.avm_readdata    = '0;
    bus_if.avm_waitrequest = 1'b0;
    repeat (2) tick();

    chk("rst_req_ready", bus_if.req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_avm_read", bus_if.avm_read, 1'b0);
    chk("rst_be", bus_if.avm_byteenable, 4'b0000);
    chk("rst_we", bus_if.write_enable, 1'b0);
    chk("rst_wdata", bus_if.reg_data_in_1, 32'h0);
    reset = 1'b1;
    tick();

    // LB, offset 3, no wait states
    bus_if.avm_readdata = 32'h80FF_1234;
    issue(3'd0, 32'h0000_1003, 5'd5, 32'h0);
    chk("lb_avm_read", bus_if.avm_read, 1'b1);
    chk("lb_addr", bus_if.avm_address, 32'h0000_1000);
    chk("lb_be", bus_if.avm_byteenable, 4'b1000);
    chk("lb_ready_low", bus_if.req_ready, 1'b0);
    chk("lb_busy", busy, 1'b1);
    chk("lb_we_early", bus_if.write_enable, 1'b0);
    tick();
    chk("lb_we", bus_if.write_enable, 1'b1);
    chk("lb_wa", bus_if.write_address, 5'd5);
    chk("lb_wdata", bus_if.reg_data_in_1, 32'hFFFF_FF80);
    chk("lb_read_off", bus_if.avm_read, 1'b0);
    tick();
    chk("lb_we_off", bus_if.write_enable, 1'b0);
    chk("lb_ready_back", bus_if.req_ready, 1'b1);
    chk("lb_busy_off", busy, 1'b0);

    // LHU upper half with three wait states, issued back-to-back
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    bus_if.avm_waitrequest = 1'b1;
    bus_if.avm_readdata    = 32'hBEEF_0001;
    issue(3'd3, 32'h0000_2002, 5'd7, 32'h0);
    chk("lhu_addr", bus_if.avm_address, 32'h0000_2000);
    for (int i = 0; i < 4; i++) begin
      chk("lhu_read_held", bus_if.avm_read, 1'b1);
      chk("lhu_be_held", bus_if.avm_byteenable, 4'b1100);
      if (i == 3) bus_if.avm_waitrequest = 1'b0;
      tick();
    end
    chk("lhu_we", bus_if.write_enable, 1'b1);
    chk("lhu_wa", bus_if.write_address, 5'd7);
    chk("lhu_wdata", bus_if.reg_data_in_1, 32'h0000_BEEF);
    tick();
    chk("lhu_read_cycles", rd_cnt - rd0, 4);
    chk("lhu_write_once", wr_cnt - wr0, 1);

    // Misaligned LW
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    issue(3'd4, 32'h0000_3001, 5'd4, 32'h0);
    chk("lwmis_err", err, 1'b1);
    chk("lwmis_read", bus_if.avm_read, 1'b0);
    chk("lwmis_busy", busy, 1'b1);
    tick();
    chk("lwmis_err_off", err, 1'b0);
    chk("lwmis_ready", bus_if.req_ready, 1'b1);
    tick();
    chk("lwmis_no_read", rd_cnt - rd0, 0);
    chk("lwmis_no_write", wr_cnt - wr0, 0);

    // LWL offset 1
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    bus_if.avm_readdata = 32'hAABB_CCDD;
    issue(3'd5, 32'h0000_4001, 5'd3, 32'h1122_3344);
`ifdef LOAD_UNALIGNED_EN
    chk("lwl_read", bus_if.avm_read, 1'b1);
    chk("lwl_be", bus_if.avm_byteenable, 4'b1111);
    tick();
    chk("lwl_we", bus_if.write_enable, 1'b1);
    chk("lwl_wa", bus_if.write_address, 5'd3);
    chk("lwl_wdata", bus_if.reg_data_in_1, 32'hCCDD_3344);
    tick();
`else
    chk("lwl_err", err, 1'b1);
    chk("lwl_read", bus_if.avm_read, 1'b0);
    tick();
    chk("lwl_err_off", err, 1'b0);
    tick();
    chk("lwl_no_read", rd_cnt - rd0, 0);
    chk("lwl_no_write", wr_cnt - wr0, 0);
`endif

    // LW that times out after 4 waitrequest cycles
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    bus_if.avm_waitrequest = 1'b1;
    issue(3'd4, 32'h0000_5000, 5'd6, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("to_read_held", bus_if.avm_read, 1'b1);
      chk("to_err_low", err, 1'b0);
      tick();
    end
    chk("to_read_drop", bus_if.avm_read, 1'b0);
    chk("to_err", err, 1'b1);
    tick();
    chk("to_err_off", err, 1'b0);
    chk("to_ready", bus_if.req_ready, 1'b1);
    chk("to_read_cycles", rd_cnt - rd0, 4);
    chk("to_no_write", wr_cnt - wr0, 0);
    bus_if.avm_waitrequest = 1'b0;

    // LH to r0: read happens, write suppressed
    wr0 = wr_cnt;
    bus_if.avm_readdata = 32'h0000_8001;
    issue(3'd2, 32'h0000_6000, 5'd0, 32'h0);
    chk("r0_read", bus_if.avm_read, 1'b1);
    chk("r0_be", bus_if.avm_byteenable, 4'b0011);
    tick();
    chk("r0_we", bus_if.write_enable, 1'b0);
    chk("r0_busy", busy, 1'b1);
    tick();
    chk("r0_ready", bus_if.req_ready, 1'b1);
    chk("r0_no_write", wr_cnt - wr0, 0);

    // LBU offset 1, zero-extended
    bus_if.avm_readdata = 32'h1234_8056;
    issue(3'd1, 32'h0000_7001, 5'd2, 32'h0);
    chk("lbu_be", bus_if.avm_byteenable, 4'b0010);
    tick();
    chk("lbu_we", bus_if.write_enable, 1'b1);
    chk("lbu_wdata", bus_if.reg_data_in_1, 32'h0000_0080);
    tick();

    // Reset in the second READ cycle abandons the load
    wr0 = wr_cnt;
    bus_if.avm_waitrequest = 1'b1;
    issue(3'd4, 32'h0000_8000, 5'd9, 32'h0);
    chk("rr_read1", bus_if.avm_read, 1'b1);
    tick();
    chk("rr_read2", bus_if.avm_read, 1'b1);
    reset = 1'b0;
    tick();
    chk("rr_read_drop", bus_if.avm_read, 1'b0);
    chk("rr_busy", busy, 1'b0);
    chk("rr_ready", bus_if.req_ready, 1'b1);
    reset = 1'b1;
    bus_if.avm_waitrequest = 1'b0;
    repeat (3) tick();
    chk("rr_no_write", wr_cnt - wr0, 0);
    chk("rr_we", bus_if.write_enable, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
